// File: rtl/receiver_deframer.sv
// ---------------------------------------------------------------------------
// receiver_deframer
//
// Bit-serial 802.11a receive deframer. It hunts for the alternating PLCP
// preamble, parses and checks the SIGNAL field, recovers the scrambler seed
// from the SERVICE field, and delivers descrambled PSDU bits. Pad bits up to
// the OFDM symbol boundary are consumed before FrameDone is pulsed.
//
// Ports
//   Clock        in   1   rising-edge clock
//   Reset        in   1   asynchronous active-low reset
//   InValid      in   1   Input is sampled only when high
//   Input        in   1   received line bit
//   Output       out  1   descrambled PSDU bit
//   OutputValid  out  1   one-cycle strobe per PSDU bit
//   Rate         out  4   RATE field of the last accepted header
//   Length       out  12  LENGTH field (octets) of the last accepted header
//   SignalValid  out  1   pulse: SIGNAL field accepted
//   HeaderError  out  1   pulse: SIGNAL field rejected
//   FrameDone    out  1   pulse: last tail/pad bit consumed
//   Busy         out  1   high whenever the deframer is not hunting
//
// state        | meaning
// -------------+-------------------------------------------------------------
// HUNT         | look for PREAMBLE_BITS alternating bits ending in 0
// SIG_RATE     | 4 RATE bits, first bit is Rate[3]
// SIG_RSVD     | reserved bit, must be 0
// SIG_LENGTH   | 12 LENGTH bits, MSB first
// SIG_PARITY   | even parity over RATE/RSVD/LENGTH; header accept/reject
// SIG_TAIL     | 6 tail bits, not checked; header published on the last one
// DATA_SERVICE | 16 SERVICE bits; first 7 load the descrambler
// DATA_PSDU    | 8*Length descrambled payload bits
// DATA_TAIL    | 6 descrambled tail bits, discarded
// DATA_PAD     | pad bits up to the next N_DBPS boundary
// ---------------------------------------------------------------------------
module receiver_deframer #(
  parameter int PREAMBLE_BITS = 96,
  parameter int N_DBPS        = 24
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        InValid,
  input  logic        Input,
  output logic        Output,
  output logic        OutputValid,
  output logic [3:0]  Rate,
  output logic [11:0] Length,
  output logic        SignalValid,
  output logic        HeaderError,
  output logic        FrameDone,
  output logic        Busy
);

  localparam int RUN_W = $clog2(PREAMBLE_BITS + 1);
  localparam int SYM_W = (N_DBPS > 1) ? $clog2(N_DBPS) : 1;

  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(PREAMBLE_BITS);
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(N_DBPS - 1);

  typedef enum logic [3:0] {
    S_HUNT,
    S_SIG_RATE,
    S_SIG_RSVD,
    S_SIG_LENGTH,
    S_SIG_PARITY,
    S_SIG_TAIL,
    S_DATA_SERVICE,
    S_DATA_PSDU,
    S_DATA_TAIL,
    S_DATA_PAD
  } state_t;

  state_t state_q, state_d;

  // preamble hunt
  logic [RUN_W-1:0] run_q, run_d;
  logic             prev_q, prev_d;

  // shared per-state bit counter; wide enough for the PSDU (8 * 4095 bits)
  logic [14:0] cnt_q, cnt_d;

  // SIGNAL shadows
  logic [3:0]  rate_sh_q, rate_sh_d;
  logic [11:0] len_sh_q, len_sh_d;
  logic        rsvd_q, rsvd_d;
  logic        par_q, par_d;

  // descrambler and symbol position
  logic [6:0]       lfsr_q, lfsr_d;
  logic [SYM_W-1:0] sym_q, sym_d;

  // registered outputs
  logic        out_q, out_d;
  logic        out_vld_q, out_vld_d;
  logic [3:0]  rate_q, rate_d;
  logic [11:0] len_q, len_d;
  logic        sig_vld_q, sig_vld_d;
  logic        hdr_err_q, hdr_err_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  // combinational helpers
  logic             fb;
  logic             descr;
  logic [SYM_W-1:0] sym_inc;
  logic [RUN_W-1:0] run_inc;
  logic [RUN_W-1:0] run_next;
  logic [14:0]      psdu_last;
  logic             hdr_bad;

  assign fb        = lfsr_q[6] ^ lfsr_q[3];
  assign descr     = Input ^ fb;
  assign sym_inc   = (sym_q == SYM_LAST) ? '0 : sym_q + SYM_W'(1);
  assign run_inc   = (run_q == RUN_LOCK) ? run_q : run_q + RUN_W'(1);
  // Length is never 0 here: a zero-length header is rejected before DATA.
  assign psdu_last = {len_q, 3'b000} - 15'd1;
  assign hdr_bad   = (par_q ^ Input) | rsvd_q | (len_sh_q == 12'd0);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_HUNT;
      run_q     <= '0;
      prev_q    <= 1'b0;
      cnt_q     <= '0;
      rate_sh_q <= '0;
      len_sh_q  <= '0;
      rsvd_q    <= 1'b0;
      par_q     <= 1'b0;
      lfsr_q    <= '0;
      sym_q     <= '0;
      out_q     <= 1'b0;
      out_vld_q <= 1'b0;
      rate_q    <= '0;
      len_q     <= '0;
      sig_vld_q <= 1'b0;
      hdr_err_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      prev_q    <= prev_d;
      cnt_q     <= cnt_d;
      rate_sh_q <= rate_sh_d;
      len_sh_q  <= len_sh_d;
      rsvd_q    <= rsvd_d;
      par_q     <= par_d;
      lfsr_q    <= lfsr_d;
      sym_q     <= sym_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      rate_q    <= rate_d;
      len_q     <= len_d;
      sig_vld_q <= sig_vld_d;
      hdr_err_q <= hdr_err_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    prev_d    = prev_q;
    cnt_d     = cnt_q;
    rate_sh_d = rate_sh_q;
    len_sh_d  = len_sh_q;
    rsvd_d    = rsvd_q;
    par_d     = par_q;
    lfsr_d    = lfsr_q;
    sym_d     = sym_q;
    out_d     = out_q;
    out_vld_d = 1'b0;
    rate_d    = rate_q;
    len_d     = len_q;
    sig_vld_d = 1'b0;
    hdr_err_d = 1'b0;
    done_d    = 1'b0;
    run_next  = run_q;

    if (InValid) begin
      case (state_q)
        S_HUNT: begin
          prev_d = Input;
          // a repeated bit restarts the run; a repeated 1 already counts as
          // the first bit of a new preamble
          if (Input != prev_q) run_next = run_inc;
          else                 run_next = {{(RUN_W-1){1'b0}}, Input};
          if ((run_next == RUN_LOCK) && !Input) begin
            state_d = S_SIG_RATE;
            run_d   = '0;
            cnt_d   = '0;
            par_d   = 1'b0;
          end else begin
            run_d   = run_next;
          end
        end

        S_SIG_RATE: begin
          rate_sh_d = {rate_sh_q[2:0], Input};
          par_d     = par_q ^ Input;
          if (cnt_q == 15'd3) begin
            state_d = S_SIG_RSVD;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + 15'd1;
          end
        end

        S_SIG_RSVD: begin
          rsvd_d  = Input;
          par_d   = par_q ^ Input;
          state_d = S_SIG_LENGTH;
          cnt_d   = '0;
        end

        S_SIG_LENGTH: begin
          len_sh_d = {len_sh_q[10:0], Input};
          par_d    = par_q ^ Input;
          if (cnt_q == 15'd11) begin
            state_d = S_SIG_PARITY;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + 15'd1;
          end
        end

        S_SIG_PARITY: begin
          par_d = par_q ^ Input;
          cnt_d = '0;
          if (hdr_bad) begin
            hdr_err_d = 1'b1;
            state_d   = S_HUNT;
          end else begin
            state_d   = S_SIG_TAIL;
          end
        end

        S_SIG_TAIL: begin
          if (cnt_q == 15'd5) begin
            rate_d    = rate_sh_q;
            len_d     = len_sh_q;
            sig_vld_d = 1'b1;
            state_d   = S_DATA_SERVICE;
            cnt_d     = '0;
            sym_d     = '0;
          end else begin
            cnt_d     = cnt_q + 15'd1;
          end
        end

        S_DATA_SERVICE: begin
          sym_d = sym_inc;
          // the SERVICE field starts with 7 zero bits, so the first 7 line
          // bits are the transmitter's scrambler output, i.e. its state
          if (cnt_q < 15'd7) lfsr_d = {lfsr_q[5:0], Input};
          else               lfsr_d = {lfsr_q[5:0], fb};
          if (cnt_q == 15'd15) begin
            state_d = S_DATA_PSDU;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + 15'd1;
          end
        end

        S_DATA_PSDU: begin
          sym_d     = sym_inc;
          lfsr_d    = {lfsr_q[5:0], fb};
          out_d     = descr;
          out_vld_d = 1'b1;
          if (cnt_q == psdu_last) begin
            state_d = S_DATA_TAIL;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + 15'd1;
          end
        end

        S_DATA_TAIL: begin
          sym_d  = sym_inc;
          lfsr_d = {lfsr_q[5:0], fb};
          if (cnt_q == 15'd5) begin
            cnt_d = '0;
            if (sym_inc == '0) begin
              done_d  = 1'b1;
              state_d = S_HUNT;
            end else begin
              state_d = S_DATA_PAD;
            end
          end else begin
            cnt_d = cnt_q + 15'd1;
          end
        end

        S_DATA_PAD: begin
          sym_d  = sym_inc;
          lfsr_d = {lfsr_q[5:0], fb};
          if (sym_inc == '0) begin
            done_d  = 1'b1;
            state_d = S_HUNT;
          end
        end

        default: begin
          state_d = S_HUNT;
          run_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != S_HUNT);
  end

  assign Output      = out_q;
  assign OutputValid = out_vld_q;
  assign Rate        = rate_q;
  assign Length      = len_q;
  assign SignalValid = sig_vld_q;
  assign HeaderError = hdr_err_q;
  assign FrameDone   = done_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_receiver_deframer.sv
module tb_receiver_deframer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_bit;
  logic        out_bit;
  logic        out_valid;
  logic [3:0]  rate;
  logic [11:0] length;
  logic        sig_valid;
  logic        hdr_err;
  logic        frame_done;
  logic        busy;

  receiver_deframer #(
    .PREAMBLE_BITS(96),
    .N_DBPS(24)
  ) dut (
    .Clock(clk),
    .Reset(rst_n),
    .InValid(in_valid),
    .Input(in_bit),
    .Output(out_bit),
    .OutputValid(out_valid),
    .Rate(rate),
    .Length(length),
    .SignalValid(sig_valid),
    .HeaderError(hdr_err),
    .FrameDone(frame_done),
    .Busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic b;
    int   idx;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  int bits_sent  = 0;
  int sig_start  = 0;
  int data_start = 0;
  bit gap_mode   = 0;
  logic last_valid = 1'b0;

  int sv_cnt = 0, he_cnt = 0, fd_cnt = 0, ov_cnt = 0, busy_cnt = 0;
  int fd_bits = 0;
  logic [3:0]  sv_rate = '0;
  logic [11:0] sv_len  = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // one valid line bit; optionally pushes the PSDU bit it should produce
  task automatic send_bit(input logic b, input logic pv, input logic pb);
    exp_t e;
    in_valid = 1'b1;
    in_bit   = b;
    if (pv) begin
      e.b   = pb;
      e.idx = bits_sent + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    bits_sent++;
    #1;
    in_valid = 1'b0;
    in_bit   = 1'($urandom_range(0, 1));
    if (gap_mode) begin
      repeat (2) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic send_frame(input logic [3:0] f_rate, input logic [11:0] f_len, input int pre_n,
                            input bit bad_par, input bit with_data, input int abort_at);
    logic [11:0] len_line;
    logic        par;
    logic [6:0]  s;
    logic        f;
    logic [7:0]  by;
    int          nbits;
    for (int i = 0; i < pre_n; i++) send_bit(1'(i % 2 == 0), 1'b0, 1'b0);
    par      = ^{f_rate, 1'b0, f_len};
    len_line = bad_par ? (f_len ^ 12'h001) : f_len;
    sig_start = bits_sent;
    for (int i = 3; i >= 0; i--) send_bit(f_rate[i], 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 11; i >= 0; i--) send_bit(len_line[i], 1'b0, 1'b0);
    send_bit(par, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b0, 1'b0);
    if (!with_data) return;
    data_start = bits_sent;
    s     = 7'b1011101;
    nbits = 0;
    for (int i = 0; i < 16; i++) begin
      f = s[6] ^ s[3];
      send_bit(f, 1'b0, 1'b0);
      s = {s[5:0], f};
      nbits++;
    end
    for (int i = 0; i < int'(f_len); i++) begin
      by = 8'(i);
      for (int j = 0; j < 8; j++) begin
        if (abort_at >= 0 && (i * 8 + j) == abort_at) return;
        f = s[6] ^ s[3];
        send_bit(by[j] ^ f, 1'b1, by[j]);
        s = {s[5:0], f};
        nbits++;
      end
    end
    for (int i = 0; i < 6; i++) begin
      f = s[6] ^ s[3];
      send_bit(f, 1'b0, 1'b0);
      s = {s[5:0], f};
      nbits++;
    end
    while (nbits % 24 != 0) begin
      f = s[6] ^ s[3];
      send_bit(f, 1'b0, 1'b0);
      s = {s[5:0], f};
      nbits++;
    end
  endtask

  task automatic frame_test(input string tag, input logic [3:0] f_rate, input logic [11:0] f_len,
                            input int pre_n, input bit bad_par, input bit gap,
                            input bit with_data, input int exp_data_bits);
    int sv0, he0, fd0, ov0, busy0;
    sv0 = sv_cnt; he0 = he_cnt; fd0 = fd_cnt; ov0 = ov_cnt; busy0 = busy_cnt;
    gap_mode = gap;
    send_frame(f_rate, f_len, pre_n, bad_par, with_data, -1);
    gap_mode = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0, 1'b0);
    check_eq({tag, "_sigvalid"}, 32'(sv_cnt - sv0), 32'(with_data ? 1 : 0));
    check_eq({tag, "_hdrerr"}, 32'(he_cnt - he0), 32'(bad_par ? 1 : 0));
    check_eq({tag, "_ov_count"}, 32'(ov_cnt - ov0), with_data ? 32'(f_len) * 8 : 32'd0);
    check_eq({tag, "_framedone"}, 32'(fd_cnt - fd0), 32'(with_data ? 1 : 0));
    check_eq({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
    if (with_data) begin
      check_eq({tag, "_rate"}, 32'(sv_rate), 32'(f_rate));
      check_eq({tag, "_length"}, 32'(sv_len), 32'(f_len));
      check_eq({tag, "_data_bits"}, 32'(fd_bits), 32'(exp_data_bits));
    end
    if (pre_n < 96) check_eq({tag, "_busy_cycles"}, 32'(busy_cnt - busy0), 32'd0);
  endtask

  always @(posedge clk) last_valid <= in_valid;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (!last_valid)
        check_eq("strobe_while_invalid", 32'({out_valid, sig_valid, hdr_err, frame_done}), 32'd0);
      if (out_valid) begin
        ov_cnt++;
        if (sb.size() == 0) begin
          check_eq("ov_unexpected", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check_eq("psdu_bit", 32'(out_bit), 32'(e.b));
          check_eq("psdu_latency", 32'(bits_sent), 32'(e.idx));
        end
      end
      if (sig_valid) begin
        sv_cnt++;
        sv_rate = rate;
        sv_len  = length;
        check_eq("sigvalid_latency", 32'(bits_sent - sig_start), 32'd24);
      end
      if (hdr_err) begin
        he_cnt++;
        check_eq("hdrerr_latency", 32'(bits_sent - sig_start), 32'd18);
        check_eq("busy_after_hdrerr", 32'(busy), 32'd0);
      end
      if (frame_done) begin
        fd_cnt++;
        fd_bits = bits_sent - data_start;
      end
      if (busy) busy_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0, ov0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs",
             32'({out_bit, out_valid, rate, length, sig_valid, hdr_err, frame_done, busy}), 32'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0, 1'b0);

    frame_test("nominal", 4'hD, 12'h010, 96, 1'b0, 1'b0, 1'b1, 168);

    frame_test("parity_err", 4'hD, 12'h010, 96, 1'b1, 1'b0, 1'b0, 0);
    check_eq("rate_held", 32'(rate), 32'hD);
    check_eq("length_held", 32'(length), 32'h010);

    frame_test("gapped", 4'hD, 12'h010, 96, 1'b0, 1'b1, 1'b1, 168);
    frame_test("len1", 4'hB, 12'h001, 96, 1'b0, 1'b0, 1'b1, 48);
    frame_test("len5", 4'h9, 12'h005, 96, 1'b0, 1'b0, 1'b1, 72);

    fd0 = fd_cnt;
    ov0 = ov_cnt;
    gap_mode = 1'b0;
    send_frame(4'hD, 12'h010, 96, 1'b0, 1'b1, 40);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_outputs",
             32'({out_bit, out_valid, rate, length, sig_valid, hdr_err, frame_done, busy}), 32'd0);
    check_eq("abort_ov_count", 32'(ov_cnt - ov0), 32'd40);
    check_eq("abort_sb_left", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort_no_framedone", 32'(fd_cnt - fd0), 32'd0);
    frame_test("after_abort", 4'hD, 12'h010, 96, 1'b0, 1'b0, 1'b1, 168);

    frame_test("pre95_nolock", 4'hD, 12'h010, 95, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 30; i++) send_bit(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) send_bit(1'(i % 2 == 0), 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    frame_test("junk_prefix", 4'h5, 12'h002, 96, 1'b0, 1'b0, 1'b1, 48);

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
